scan_chain_ctrl: RTL and testbench
==================================

// Module: scan_chain_ctrl
// PURPOSE
//  Upstream driver for a chain of negedge-clocked scan flops (async active-low reset).
//  Accepts parallel test patterns, serialises them onto the chain's SE/SI, and runs capture pulses.
//  Unloads each captured response through the chain's last-flop Q (so) while the next pattern loads.
//  Gates the chain clock so stalls never corrupt chain contents; sits between pattern source and chain.
// PARAMETERS
//  CHAIN_LEN       16  scan flops in chain, 2..256
//  CAPTURE_CYCLES  1   chain clocks with SE=0 per capture, 1..4
// PORTS
//  CLK           in   1          single clock; controller regs update on posedge
//  RSTB          in   1          asynchronous reset, active low
//  pat_valid     in   1          pattern available
//  pat_ready     out  1          pattern accepted at posedge where valid&ready
//  pat_data      in   CHAIN_LEN  bit i -> chain position i (0 = flop nearest SI)
//  unload_req    in   1          unload last capture with no new pattern (end of test)
//  se            out  1          scan enable to chain
//  si            out  1          scan in to chain position 0
//  so            in   1          Q of chain position CHAIN_LEN-1
//  chain_clk_en  out  1          enable for chain clock gate; chain advances on negedge after posedge setting it
//  rsp_valid     out  1          response held until rsp_ready
//  rsp_ready     in   1          consumer ready
//  rsp_data      out  CHAIN_LEN  bit i = value captured in chain position i
//  busy          out  1          state != IDLE
//  pattern_cnt   out  16         captures completed, wraps at 16'hFFFF -> 0
// BEHAVIOUR
//  Reset (RSTB low, async): state IDLE; se, si, chain_clk_en, rsp_valid, busy = 0; rsp_data, pattern_cnt = 0;
//   pat_ready = 0; unload_pending cleared. Mid-operation reset aborts shift/capture; chain contents undefined.
//  se/si/chain_clk_en registered on posedge -> half-cycle setup to chain negedge.
//  so sampled on posedge before each shift negedge.
//  States: IDLE, SHIFT, CAPTURE, WAIT.
//  pat_ready = (IDLE|WAIT) & ~rsp_valid & RSTB (combinational).
//  Accept at edge E:
//   - cycles E..E+N-1: SHIFT; se=1, clk_en=1; si = pat_data[N-1] first, down to pat_data[0].
//   - cycles E+N..E+N+C-1: CAPTURE; se=0, clk_en=1.
//   - then WAIT; clk_en=0, se held 1, si=0.
//   - unload_pending set at end of CAPTURE; pattern_cnt +1.
//  SHIFT entered with unload_pending: so bits shifted in MSB-first. At edge E+N: rsp_data <= unloaded word,
//   rsp_valid <= 1, unload_pending cleared.
//  In IDLE/WAIT: pat_valid has priority over unload_req.
//   - unload_req & unload_pending & ~rsp_valid: SHIFT with si=0, no CAPTURE, then IDLE.
//   - unload_req without pending capture: ignored.
//  WAIT with no request: remain, clk_en=0 (chain frozen, capture preserved indefinitely).
//  rsp_valid falls at the edge where rsp_valid&rsp_ready. Stalled rsp_ready blocks the next accept only.
//  Single shift register (N bits) serves load and unload: shift left, MSB -> si, so -> LSB.
// STRUCTURE
//  scan_ctrl_pkg: state enum, CHAIN_LEN range checks, shift-count width function.
//  Sub-module scan_shift_reg: N-bit parallel-load / serial-out / serial-in register with enable.
//  Top holds FSM, shift/capture counters, response register, pattern_cnt.
// TESTING
//  Bench models 16-flop negedge scan chain with gated clock; D inputs = ~Q functional logic.
//  1 Reset, pat 16'hA5C3 -> si sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; clk_en high 17 cycles; no rsp.
//  2 Second pat 16'h0001 back-to-back -> rsp_data=16'h5A3C (~A5C3), rsp_valid at accept+16.
//  3 Hold rsp_ready=0 after test 2 -> pat_ready=0, clk_en=0 for 50 cycles; release -> accept next cycle; rsp intact.
//  4 unload_req after capture of 16'hFFFF -> si all 0, rsp_data=16'h0000, then IDLE, busy=0.
//  5 RSTB low mid-SHIFT (cycle 7) -> all outputs 0 at once; next unload_req ignored; pattern_cnt=0.
//  6 pat_valid & unload_req same cycle in WAIT -> pattern accepted, unload overlapped.

Source files
------------

// File: rtl/scan_ctrl_pkg.sv
// Shared types and elaboration helpers for the scan chain controller.
// Parameter range limits and the shift/capture counter width live here.
package scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_WAIT    = 2'd3
  } scan_state_e;

  localparam int CHAIN_LEN_MIN      = 2;
  localparam int CHAIN_LEN_MAX      = 256;
  localparam int CAPTURE_CYCLES_MIN = 1;
  localparam int CAPTURE_CYCLES_MAX = 4;

  function automatic bit params_ok(input int chain_len, input int capture_cycles);
    return (chain_len >= CHAIN_LEN_MIN) && (chain_len <= CHAIN_LEN_MAX) &&
           (capture_cycles >= CAPTURE_CYCLES_MIN) && (capture_cycles <= CAPTURE_CYCLES_MAX);
  endfunction

  // One counter serves both shift (0..N-1) and capture (0..3) phases.
  function automatic int cnt_width(input int chain_len);
    int w;
    w = $clog2(chain_len);
    return (w < 2) ? 2 : w;
  endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load / serial-in register; shifts toward the MSB, sin enters at bit 0.
// Load has priority over shift.
module scan_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic prev;
      logic bit_reg;

      if (gi == 0) begin : g_head
        assign prev = sin;
      end else begin : g_tail
        assign prev = q[gi-1];
      end

      always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
          bit_reg <= 1'b0;
        end else if (load) begin
          bit_reg <= load_data[gi];
        end else if (shift_en) begin
          bit_reg <= prev;
        end
      end

      assign q[gi] = bit_reg;
    end
  endgenerate

endmodule

// File: rtl/scan_chain_ctrl.sv
// Drives a negedge scan chain: loads patterns over se/si, pulses capture, and
// unloads the previous capture through so while the next pattern shifts in.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN      = 16,
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_data,
  input  logic                 unload_req,
  output logic                 se,
  output logic                 si,
  input  logic                 so,
  output logic                 chain_clk_en,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 busy,
  output logic [15:0]          pattern_cnt
);

  localparam int CNT_W = cnt_width(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_SHIFT   = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_CAPTURE = CNT_W'(CAPTURE_CYCLES - 1);

  generate
    if (!params_ok(CHAIN_LEN, CAPTURE_CYCLES)) begin : g_param_check
      $error("scan_chain_ctrl: CHAIN_LEN or CAPTURE_CYCLES out of range");
    end
  endgenerate

  scan_state_e          state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 se_reg, se_next;
  logic                 si_reg, si_next;
  logic                 clk_en_reg, clk_en_next;
  logic                 rsp_valid_reg, rsp_valid_next;
  logic [CHAIN_LEN-1:0] rsp_data_reg, rsp_data_next;
  logic [15:0]          pattern_cnt_reg, pattern_cnt_next;
  logic                 unload_pending_reg, unload_pending_next;
  logic                 unload_mode_reg, unload_mode_next;
  logic                 harvest_reg, harvest_next;

  logic                 sr_load, sr_shift;
  logic [CHAIN_LEN-1:0] sr_load_data, sr_q;
  logic                 idle_or_wait, pat_go, unload_go;

  // so is folded into the load word so the bit present before the first shift is kept.
  scan_shift_reg #(.WIDTH(CHAIN_LEN)) u_shift_reg (
    .CLK       (CLK),
    .RSTB      (RSTB),
    .load      (sr_load),
    .load_data (sr_load_data),
    .shift_en  (sr_shift),
    .sin       (so),
    .q         (sr_q)
  );

  assign idle_or_wait = (state_reg == ST_IDLE) || (state_reg == ST_WAIT);
  assign pat_ready    = idle_or_wait && !rsp_valid_reg && RSTB;
  assign pat_go       = pat_valid && pat_ready;
  assign unload_go    = !pat_valid && unload_req && unload_pending_reg && idle_or_wait && !rsp_valid_reg;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_reg          <= ST_IDLE;
      cnt_reg            <= '0;
      se_reg             <= 1'b0;
      si_reg             <= 1'b0;
      clk_en_reg         <= 1'b0;
      rsp_valid_reg      <= 1'b0;
      rsp_data_reg       <= '0;
      pattern_cnt_reg    <= '0;
      unload_pending_reg <= 1'b0;
      unload_mode_reg    <= 1'b0;
      harvest_reg        <= 1'b0;
    end else begin
      state_reg          <= state_next;
      cnt_reg            <= cnt_next;
      se_reg             <= se_next;
      si_reg             <= si_next;
      clk_en_reg         <= clk_en_next;
      rsp_valid_reg      <= rsp_valid_next;
      rsp_data_reg       <= rsp_data_next;
      pattern_cnt_reg    <= pattern_cnt_next;
      unload_pending_reg <= unload_pending_next;
      unload_mode_reg    <= unload_mode_next;
      harvest_reg        <= harvest_next;
    end
  end

  always_comb begin
    state_next          = state_reg;
    cnt_next            = cnt_reg;
    se_next             = se_reg;
    si_next             = si_reg;
    clk_en_next         = clk_en_reg;
    rsp_valid_next      = rsp_valid_reg;
    rsp_data_next       = rsp_data_reg;
    pattern_cnt_next    = pattern_cnt_reg;
    unload_pending_next = unload_pending_reg;
    unload_mode_next    = unload_mode_reg;
    harvest_next        = harvest_reg;
    sr_load             = 1'b0;
    sr_load_data        = '0;
    sr_shift            = 1'b0;

    if (rsp_valid_reg && rsp_ready) begin
      rsp_valid_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE, ST_WAIT: begin
        if (pat_go) begin
          state_next       = ST_SHIFT;
          cnt_next         = '0;
          se_next          = 1'b1;
          clk_en_next      = 1'b1;
          si_next          = pat_data[CHAIN_LEN-1];
          sr_load          = 1'b1;
          sr_load_data     = {pat_data[CHAIN_LEN-2:0], so};
          unload_mode_next = 1'b0;
          harvest_next     = unload_pending_reg;
        end else if (unload_go) begin
          state_next       = ST_SHIFT;
          cnt_next         = '0;
          se_next          = 1'b1;
          clk_en_next      = 1'b1;
          si_next          = 1'b0;
          sr_load          = 1'b1;
          sr_load_data     = {{(CHAIN_LEN-1){1'b0}}, so};
          unload_mode_next = 1'b1;
          harvest_next     = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (cnt_reg == LAST_SHIFT) begin
          if (harvest_reg) begin
            rsp_data_next       = sr_q;
            rsp_valid_next      = 1'b1;
            unload_pending_next = 1'b0;
          end
          cnt_next = '0;
          se_next  = 1'b0;
          si_next  = 1'b0;
          if (unload_mode_reg) begin
            state_next  = ST_IDLE;
            clk_en_next = 1'b0;
          end else begin
            state_next  = ST_CAPTURE;
            clk_en_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
          si_next  = sr_q[CHAIN_LEN-1];
          sr_shift = 1'b1;
        end
      end

      ST_CAPTURE: begin
        if (cnt_reg == LAST_CAPTURE) begin
          // Leave se high while frozen so a later restart begins in shift mode.
          state_next          = ST_WAIT;
          se_next             = 1'b1;
          si_next             = 1'b0;
          clk_en_next         = 1'b0;
          unload_pending_next = 1'b1;
          pattern_cnt_next    = pattern_cnt_reg + 16'd1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign se           = se_reg;
  assign si           = si_reg;
  assign chain_clk_en = clk_en_reg;
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_data     = rsp_data_reg;
  assign busy         = (state_reg != ST_IDLE);
  assign pattern_cnt  = pattern_cnt_reg;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: 16-flop negedge scan chain model whose functional
// logic inverts each flop, with a response scoreboard checked on handshake.
module tb_scan_chain_ctrl;
  localparam int N = 16;

  logic         CLK = 1'b0;
  logic         RSTB = 1'b0;
  logic         pat_valid = 1'b0;
  logic [N-1:0] pat_data = '0;
  logic         unload_req = 1'b0;
  logic         rsp_ready = 1'b1;
  logic         pat_ready, se, si, so, chain_clk_en, rsp_valid, busy;
  logic [N-1:0] rsp_data;
  logic [15:0]  pattern_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [N-1:0] chain;
  logic [N-1:0] exp_q[$];

  typedef struct {
    logic         is_unload;
    logic [N-1:0] pat;
    logic         has_rsp;
    logic [N-1:0] exp_rsp;
  } vec_t;
  vec_t vecs[5];

  always #5 CLK = ~CLK;

  scan_chain_ctrl #(.CHAIN_LEN(N), .CAPTURE_CYCLES(1)) dut (
    .CLK          (CLK),
    .RSTB         (RSTB),
    .pat_valid    (pat_valid),
    .pat_ready    (pat_ready),
    .pat_data     (pat_data),
    .unload_req   (unload_req),
    .se           (se),
    .si           (si),
    .so           (so),
    .chain_clk_en (chain_clk_en),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .busy         (busy),
    .pattern_cnt  (pattern_cnt)
  );

  // Gated negedge chain; functional D input is the inverse of each flop's Q.
  always @(negedge CLK or negedge RSTB) begin
    if (!RSTB) chain <= '0;
    else if (chain_clk_en) chain <= se ? {chain[N-2:0], si} : ~chain;
  end
  assign so = chain[N-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard pop: the handshake edge follows this negedge.
  always @(negedge CLK) begin : sb_monitor
    logic [N-1:0] e;
    if (RSTB && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp_unexpected: actual %0h required none", rsp_data);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic accept_pattern(input logic [N-1:0] p, input logic push, input logic [N-1:0] e);
    bit ok;
    ok = 1'b0;
    if (push) exp_q.push_back(e);
    pat_data  = p;
    pat_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = pat_ready;
      step();
    end
    pat_valid = 1'b0;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: actual pat_ready 0 required 1 within 100 cycles");
    end
  endtask

  task automatic check_shift(input logic [N-1:0] p, input logic has_rsp);
    for (int k = 0; k < N; k++) begin
      chk("se_shift", se, 1);
      chk("clk_en_shift", chain_clk_en, 1);
      chk("si_bit", si, p[N-1-k]);
      step();
    end
    chk("se_capture", se, 0);
    chk("clk_en_capture", chain_clk_en, 1);
    chk("rsp_valid_at_n", rsp_valid, has_rsp);
    step();
    chk("clk_en_wait", chain_clk_en, 0);
    chk("se_wait", se, 1);
    chk("busy_wait", busy, 1);
    $display("pattern %h shifted, response expected %0d", p, has_rsp);
  endtask

  task automatic unload_seq(input logic [N-1:0] e);
    exp_q.push_back(e);
    unload_req = 1'b1;
    step();
    unload_req = 1'b0;
    for (int k = 0; k < N; k++) begin
      chk("si_unload", si, 0);
      chk("se_unload", se, 1);
      chk("clk_en_unload", chain_clk_en, 1);
      step();
    end
    chk("rsp_valid_unload", rsp_valid, 1);
    chk("busy_after_unload", busy, 0);
    chk("clk_en_after_unload", chain_clk_en, 0);
    chk("se_after_unload", se, 0);
    $display("unload done, expected response %h", e);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_se"}, se, 0);
    chk({tag, "_si"}, si, 0);
    chk({tag, "_clk_en"}, chain_clk_en, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_pattern_cnt"}, pattern_cnt, 0);
    chk({tag, "_pat_ready"}, pat_ready, 0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 16'hA5C3, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 16'h0001, 1'b1, 16'h5A3C};
    vecs[2] = '{1'b0, 16'h1234, 1'b1, 16'hFFFE};
    vecs[3] = '{1'b0, 16'hFFFF, 1'b1, 16'hEDCB};
    vecs[4] = '{1'b1, 16'h0000, 1'b1, 16'h0000};

    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge CLK);
    @(negedge CLK) RSTB = 1'b1;
    step();
    chk("pat_ready_idle", pat_ready, 1);

    // Back-to-back patterns and an end-of-test unload
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].is_unload) begin
        unload_seq(vecs[i].exp_rsp);
        step();
      end else begin
        accept_pattern(vecs[i].pat, vecs[i].has_rsp, vecs[i].exp_rsp);
        check_shift(vecs[i].pat, vecs[i].has_rsp);
      end
    end
    chk("pattern_cnt_table", pattern_cnt, 4);

    // Consumer stall holds the response and freezes the chain
    rsp_ready = 1'b0;
    accept_pattern(16'h8001, 1'b0, 16'h0000);
    check_shift(16'h8001, 1'b0);
    accept_pattern(16'h0F00, 1'b1, 16'h7FFE);
    check_shift(16'h0F00, 1'b1);
    pat_data  = 16'h4321;
    pat_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      step();
      chk("stall_pat_ready", pat_ready, 0);
      chk("stall_clk_en", chain_clk_en, 0);
      chk("stall_rsp_valid", rsp_valid, 1);
    end
    rsp_ready = 1'b1;
    step();
    chk("release_rsp_valid", rsp_valid, 0);
    chk("release_pat_ready", pat_ready, 1);
    accept_pattern(16'h4321, 1'b1, 16'hF0FF);
    check_shift(16'h4321, 1'b1);
    chk("pattern_cnt_stall", pattern_cnt, 7);

    // pat_valid and unload_req together in WAIT: pattern wins, unload overlaps
    unload_req = 1'b1;
    accept_pattern(16'h00FF, 1'b1, 16'hBCDE);
    unload_req = 1'b0;
    check_shift(16'h00FF, 1'b1);
    chk("pattern_cnt_overlap", pattern_cnt, 8);

    // Reset in the middle of a shift
    accept_pattern(16'h3C3C, 1'b0, 16'h0000);
    repeat (7) step();
    RSTB = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge CLK);
    @(negedge CLK) RSTB = 1'b1;
    step();
    unload_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("ignored_unload_busy", busy, 0);
      chk("ignored_unload_clk_en", chain_clk_en, 0);
      chk("ignored_unload_rsp_valid", rsp_valid, 0);
    end
    unload_req = 1'b0;
    chk("pattern_cnt_after_reset", pattern_cnt, 0);

    // Fresh pattern after reset, then drain
    accept_pattern(16'h5555, 1'b0, 16'h0000);
    check_shift(16'h5555, 1'b0);
    unload_seq(16'hAAAA);
    step();
    chk("pattern_cnt_final", pattern_cnt, 1);
    chk("busy_final", busy, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
